// File: rtl/a51_cipher_if.sv
// Serial datapath bundle for the A5/1 cipher: key-load strobe and key,
// plaintext bit in, ciphertext bit out.
interface a51_cipher_if;
    logic [63:0] Key;
    logic        Plain;
    logic        Cipher;
    logic        Krdy;

    modport master (output Key, output Plain, output Krdy, input Cipher);
    modport slave  (input Key, input Plain, input Krdy, output Cipher);
endinterface

// File: rtl/a51_cipher.sv
// A5/1 stream cipher, one keystream bit per clock. Three majority-clocked
// LFSRs are parallel-loaded from Key; Cipher = Plain ^ keystream bit.
module a51_cipher (
    input  logic         clk,
    input  logic         rst,
    a51_cipher_if.slave  bus
);

    logic [18:0] r1_r;
    logic [21:0] r2_r;
    logic [22:0] r3_r;

    logic [18:0] r1_nxt_s;
    logic [21:0] r2_nxt_s;
    logic [22:0] r3_nxt_s;
    logic        maj_s;
    logic        z_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic fb_r1(input logic [18:0] r);
        return r[13] ^ r[16] ^ r[17] ^ r[18];
    endfunction

    function automatic logic fb_r2(input logic [21:0] r);
        return r[20] ^ r[21];
    endfunction

    function automatic logic fb_r3(input logic [22:0] r);
        return r[7] ^ r[20] ^ r[21] ^ r[22];
    endfunction

    // Majority-clocked next state: a register steps only if its clock bit matches m
    always_comb begin
        maj_s    = maj3(r1_r[8], r2_r[10], r3_r[10]);
        r1_nxt_s = r1_r;
        r2_nxt_s = r2_r;
        r3_nxt_s = r3_r;
        if (r1_r[8] == maj_s) begin
            r1_nxt_s = {r1_r[17:0], fb_r1(r1_r)};
        end else begin
            r1_nxt_s = r1_r;
        end
        if (r2_r[10] == maj_s) begin
            r2_nxt_s = {r2_r[20:0], fb_r2(r2_r)};
        end else begin
            r2_nxt_s = r2_r;
        end
        if (r3_r[10] == maj_s) begin
            r3_nxt_s = {r3_r[21:0], fb_r3(r3_r)};
        end else begin
            r3_nxt_s = r3_r;
        end
    end

    // LFSR state: reset beats key load, key load suppresses stepping that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_r <= 19'd0;
            r2_r <= 22'd0;
            r3_r <= 23'd0;
        end else if (bus.Krdy) begin
            r1_r <= bus.Key[63:45];
            r2_r <= bus.Key[44:23];
            r3_r <= bus.Key[22:0];
        end else begin
            r1_r <= r1_nxt_s;
            r2_r <= r2_nxt_s;
            r3_r <= r3_nxt_s;
        end
    end

    // Keystream from the current state; bypassed while resetting or loading
    always_comb begin
        z_s = r1_r[18] ^ r2_r[21] ^ r3_r[22];
        if (rst || bus.Krdy) begin
            bus.Cipher = bus.Plain;
        end else begin
            bus.Cipher = bus.Plain ^ z_s;
        end
    end

endmodule

// File: tb/tb_a51_cipher.sv
// Directed bench for a51_cipher: hand-computed vectors plus a 200-bit
// comparison against a small behavioural model.
module tb_a51_cipher;

    logic clk = 1'b0;
    logic rst;
    a51_cipher_if bus ();

    a51_cipher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [63:0] KEY_A = 64'h0F1571C9_AF7F6798;

    logic [18:0] m1;
    logic [21:0] m2;
    logic [22:0] m3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then settle before checking.
    task automatic drive(input logic r, input logic k, input logic p);
        @(negedge clk);
        rst       = r;
        bus.Krdy  = k;
        bus.Plain = p;
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r1"}, 64'(dut.r1_r), 64'd0);
        check({tag, "_r2"}, 64'(dut.r2_r), 64'd0);
        check({tag, "_r3"}, 64'(dut.r3_r), 64'd0);
    endtask

    task automatic model_load(input logic [63:0] k);
        m1 = k[63:45];
        m2 = k[44:23];
        m3 = k[22:0];
    endtask

    task automatic model_step();
        int  votes;
        logic m;
        votes = int'(m1[8]) + int'(m2[10]) + int'(m3[10]);
        m = (votes >= 2);
        if (m1[8]  == m) m1 = {m1[17:0], ^(m1 & 19'h72000)};
        if (m2[10] == m) m2 = {m2[20:0], ^(m2 & 22'h300000)};
        if (m3[10] == m) m3 = {m3[21:0], ^(m3 & 23'h700080)};
    endtask

    initial begin
        logic [63:0] k;
        logic [18:0] e1;
        logic [21:0] e2;
        logic [22:0] e3;
        logic        mj;
        logic        p;
        logic [2:0]  pat;

        rst       = 1'b1;
        bus.Krdy  = 1'b0;
        bus.Plain = 1'b0;
        bus.Key   = 64'd0;

        // Reset: pass-through, then all-zero registers give z=0
        drive(1'b1, 1'b0, 1'b1);
        check("rst_pass", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b0);
        check_zero("after_rst");
        for (int i = 0; i < 4; i++) begin
            p = 1'(i % 2);
            drive(1'b0, 1'b0, p);
            check("nokey_pass", 64'(bus.Cipher), 64'(p));
        end

        // Key load and first keystream bits 0,1,1
        bus.Key = KEY_A;
        drive(1'b0, 1'b1, 1'b1);
        check("krdy_pass", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("load_r1", 64'(dut.r1_r), 64'h078AB);
        check("load_r2", 64'(dut.r2_r), 64'h23935E);
        check("load_r3", 64'(dut.r3_r), 64'h7F6798);
        check("enc0", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("step1_r1", 64'(dut.r1_r), 64'h0F157);
        check("step1_r2", 64'(dut.r2_r), 64'h0726BD);
        check("step1_r3_hold", 64'(dut.r3_r), 64'h7F6798);
        check("enc1", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("enc2", 64'(bus.Cipher), 64'd0);

        // Decrypt: feed the ciphertext back in
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("dec0", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("dec1", 64'(bus.Cipher), 64'd0);
        drive(1'b0, 1'b0, 1'b0);
        check("dec2", 64'(bus.Cipher), 64'd1);

        // Mid-stream reload restarts the keystream
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("reload_z0", 64'(bus.Cipher), 64'd0);
        drive(1'b0, 1'b0, 1'b0);
        check("reload_z1", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("reload_z2", 64'(bus.Cipher), 64'd1);

        // rst and Krdy together: reset wins
        drive(1'b1, 1'b1, 1'b1);
        check("rst_krdy_pass", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b0);
        check_zero("rst_krdy");

        // Majority clocking for every clock-bit pattern; no taps are set
        for (int i = 0; i < 8; i++) begin
            pat = 3'(i);
            k = 64'd0;
            k[53] = pat[2];
            k[33] = pat[1];
            k[10] = pat[0];
            bus.Key = k;
            drive(1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
            mj = ((int'(pat[2]) + int'(pat[1]) + int'(pat[0])) >= 2);
            e1 = 19'(pat[2]) << 8;
            e2 = 22'(pat[1]) << 10;
            e3 = 23'(pat[0]) << 10;
            if (pat[2] == mj) e1 = e1 << 1;
            if (pat[1] == mj) e2 = e2 << 1;
            if (pat[0] == mj) e3 = e3 << 1;
            check($sformatf("maj%0d_r1", i), 64'(dut.r1_r), 64'(e1));
            check($sformatf("maj%0d_r2", i), 64'(dut.r2_r), 64'(e2));
            check($sformatf("maj%0d_r3", i), 64'(dut.r3_r), 64'(e3));
        end

        // 200 bits against the behavioural model
        bus.Key = KEY_A;
        model_load(KEY_A);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            p = 1'($urandom_range(0, 1));
            drive(1'b0, 1'b0, p);
            check($sformatf("model_bit%0d", i), 64'(bus.Cipher),
                  64'(p ^ m1[18] ^ m2[21] ^ m3[22]));
            model_step();
        end

        // rst pulse mid-stream clears everything
        drive(1'b1, 1'b0, 1'b1);
        check("midrst_pass", 64'(bus.Cipher), 64'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("midrst_next", 64'(bus.Cipher), 64'd1);
        check_zero("midrst");
        drive(1'b0, 1'b0, 1'b0);
        check("midrst_next2", 64'(bus.Cipher), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
